// File: rtl/sw_debounce_if.sv
// Signal bundle for the switch debouncer: raw input in, clean level, edge pulses and press count out.
interface sw_debounce_if;
  logic       D_IN;
  logic       Q;
  logic       RISE;
  logic       FALL;
  logic [7:0] PRESS_CNT;

  modport master (output D_IN, input Q, RISE, FALL, PRESS_CNT);
  modport slave  (input D_IN, output Q, RISE, FALL, PRESS_CNT);
endinterface

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronizer chain followed by a four-state stability FSM
// that accepts a new level after STABLE_CYCLES equal samples.
module sw_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          CLK,
  input  logic          RST,
  sw_debounce_if.slave  bus
);

  typedef enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW} state_t;

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  state_t                 state, state_next;
  logic [7:0]             count, count_next;
  logic                   q, rise, fall;
  logic                   rise_next, fall_next;
  logic [7:0]             press_cnt;

  assign sync_out = sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync      <= '0;
      state     <= S_LOW;
      count     <= '0;
      q         <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      press_cnt <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], bus.D_IN};
      state     <= state_next;
      count     <= count_next;
      q         <= (state_next == S_HIGH) || (state_next == S_WAIT_LOW);
      rise      <= rise_next;
      fall      <= fall_next;
      press_cnt <= press_cnt + 8'(rise_next);
    end
  end

  // The LOW/WAIT_HIGH pair and the HIGH/WAIT_LOW pair are polarity mirrors.
  always_comb begin
    state_next = state;
    count_next = count;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      S_LOW: begin
        if (sync_out) begin
          state_next = S_WAIT_HIGH;
          count_next = 8'd1;
        end else begin
          count_next = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_out) begin
          state_next = S_LOW;
          count_next = '0;
        end else if (count == LAST) begin
          state_next = S_HIGH;
          count_next = '0;
          rise_next  = 1'b1;
        end else begin
          count_next = count + 8'd1;
        end
      end
      S_HIGH: begin
        if (!sync_out) begin
          state_next = S_WAIT_LOW;
          count_next = 8'd1;
        end else begin
          count_next = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync_out) begin
          state_next = S_HIGH;
          count_next = '0;
        end else if (count == LAST) begin
          state_next = S_LOW;
          count_next = '0;
          fall_next  = 1'b1;
        end else begin
          count_next = count + 8'd1;
        end
      end
      default: begin
        state_next = S_LOW;
        count_next = '0;
      end
    endcase
  end

  assign bus.Q         = q;
  assign bus.RISE      = rise;
  assign bus.FALL      = fall;
  assign bus.PRESS_CNT = press_cnt;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random bouncing input, checked
// against a sliding-window model of the synchronized input.
module tb_sw_debounce;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned total  = 0;
  int unsigned passed = 0;

  sw_debounce_if bus ();

  sw_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: the raw input is delayed SYNC edges; a new level is accepted once the
  // last STABLE delayed samples all differ from the current output level.
  logic [SYNC-1:0]   m_sync = '0;
  logic [STABLE-1:0] m_hist = '0;
  logic              m_q    = 1'b0;
  logic              m_rise = 1'b0;
  logic              m_fall = 1'b0;
  logic [7:0]        m_pcnt = '0;

  task automatic model_edge(input logic d, input logic r);
    if (!r) begin
      m_sync = '0;
      m_hist = '0;
      m_q    = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_pcnt = '0;
    end else begin
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_hist = {m_hist[STABLE-2:0], m_sync[SYNC-1]};
      if (m_q ? (m_hist == '0) : (m_hist == '1)) begin
        m_q = ~m_q;
        if (m_q) begin
          m_rise = 1'b1;
          m_pcnt = m_pcnt + 8'd1;
        end else begin
          m_fall = 1'b1;
        end
      end
      m_sync = {m_sync[SYNC-2:0], d};
    end
  endtask

  task automatic step(input logic d, input logic r);
    @(negedge clk);
    bus.D_IN = d;
    rst      = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
  endtask

  task automatic test_reset;
    for (int unsigned i = 0; i < 6; i++) begin
      step(1'b0, (i >= 2) ? 1'b1 : 1'b0);
      total++;
      if ({bus.Q, bus.RISE, bus.FALL, bus.PRESS_CNT} !== 11'd0)
        $display("FAIL reset[%0d]: got Q=%b R=%b F=%b CNT=%0d, want all 0", i, bus.Q, bus.RISE, bus.FALL, bus.PRESS_CNT);
      else passed++;
    end
  endtask

  task automatic test_rise;
    for (int unsigned e = 1; e <= 8; e++) begin
      step(1'b1, 1'b1);
      total++;
      if (e < 6 && (bus.Q !== 1'b0 || bus.RISE !== 1'b0))
        $display("FAIL rise_early[edge %0d]: got Q=%b R=%b, want 0 0", e, bus.Q, bus.RISE);
      else if (e == 6 && (bus.Q !== 1'b1 || bus.RISE !== 1'b1 || bus.PRESS_CNT !== 8'd1))
        $display("FAIL rise_edge6: got Q=%b R=%b CNT=%0d, want 1 1 1", bus.Q, bus.RISE, bus.PRESS_CNT);
      else if (e > 6 && (bus.Q !== 1'b1 || bus.RISE !== 1'b0 || bus.PRESS_CNT !== 8'd1))
        $display("FAIL rise_after[edge %0d]: got Q=%b R=%b CNT=%0d, want 1 0 1", e, bus.Q, bus.RISE, bus.PRESS_CNT);
      else passed++;
    end
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    int unsigned rises = 0;
    int unsigned falls = 0;
    int unsigned rise_at = 0;
    pat = 8'b0011_0011;  // applied LSB first: 1,1,0,0,1,1,0,0
    for (int unsigned i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int unsigned i = 0; i < 20; i++) begin
      step((i < 8) ? pat[i] : 1'b1, 1'b1);
      if (bus.RISE === 1'b1) begin rises++; rise_at = i; end
      if (bus.FALL === 1'b1) falls++;
    end
    total++;
    if (rises != 1 || falls != 0)
      $display("FAIL bounce_pulses: got rises=%0d falls=%0d, want 1 0", rises, falls);
    else passed++;
    total++;
    if (rise_at != 13)
      $display("FAIL bounce_latency: got rise at step %0d, want 13", rise_at);
    else passed++;
  endtask

  task automatic test_glitch_high;
    int unsigned falls = 0;
    for (int unsigned i = 0; i < 13; i++) begin
      step((i < 3) ? 1'b0 : 1'b1, 1'b1);
      if (bus.FALL === 1'b1 || bus.Q !== 1'b1) falls++;
    end
    total++;
    if (falls != 0)
      $display("FAIL glitch_high: got %0d disturbed cycles, want 0", falls);
    else passed++;
    for (int unsigned e = 1; e <= 7; e++) begin
      step(1'b0, 1'b1);
      if (e >= 5) begin
        total++;
        if (bus.FALL !== (e == 6) || bus.Q !== (e < 6 ? 1'b1 : 1'b0))
          $display("FAIL fall[edge %0d]: got Q=%b F=%b, want Q=%b F=%b", e, bus.Q, bus.FALL, (e < 6), (e == 6));
        else passed++;
      end
    end
  endtask

  task automatic test_wrap;
    int unsigned rises = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int unsigned p = 1; p <= 256; p++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        step((i < 8) ? 1'b1 : 1'b0, 1'b1);
        if (bus.RISE === 1'b1) rises++;
      end
      if (p == 255) begin
        total++;
        if (bus.PRESS_CNT !== 8'd255)
          $display("FAIL wrap_255: got %0d, want 255", bus.PRESS_CNT);
        else passed++;
      end
    end
    total++;
    if (bus.PRESS_CNT !== 8'd0)
      $display("FAIL wrap_0: got %0d, want 0", bus.PRESS_CNT);
    else passed++;
    total++;
    if (rises != 256)
      $display("FAIL wrap_rises: got %0d, want 256", rises);
    else passed++;
  endtask

  task automatic test_reset_mid;
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 1'b1);
    for (int unsigned i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (bus.RISE !== 1'b0 || bus.Q !== 1'b0 || bus.PRESS_CNT !== 8'd0)
        $display("FAIL reset_mid_hold[%0d]: got Q=%b R=%b CNT=%0d, want 0 0 0", i, bus.Q, bus.RISE, bus.PRESS_CNT);
      else passed++;
    end
    for (int unsigned e = 1; e <= 7; e++) begin
      step(1'b1, 1'b1);
      total++;
      if (bus.RISE !== (e == 6) || bus.PRESS_CNT !== ((e >= 6) ? 8'd1 : 8'd0))
        $display("FAIL reset_mid_rise[edge %0d]: got R=%b CNT=%0d, want R=%b CNT=%0d", e, bus.RISE, bus.PRESS_CNT, (e == 6), (e >= 6));
      else passed++;
    end
  endtask

  task automatic test_random;
    logic lvl;
    logic r;
    int unsigned len;
    int unsigned n = 0;
    while (n < 600) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int unsigned i = 0; i < len; i++) begin
        r = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        step(lvl, r);
        n++;
        total++;
        if ({bus.Q, bus.RISE, bus.FALL, bus.PRESS_CNT} !== {m_q, m_rise, m_fall, m_pcnt} || (bus.RISE && bus.FALL))
          $display("FAIL random[%0d]: got Q=%b R=%b F=%b CNT=%0d, want Q=%b R=%b F=%b CNT=%0d",
                   n, bus.Q, bus.RISE, bus.FALL, bus.PRESS_CNT, m_q, m_rise, m_fall, m_pcnt);
        else passed++;
      end
    end
  endtask

  initial begin
    bus.D_IN = 1'b0;
    test_reset();
    test_rise();
    test_bounce();
    test_glitch_high();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flip-flops on D_IN; legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive equal synchronized samples needed to accept a new level; legal range 2..255.
REQ-003 Port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset, synchronous, active-low: RST==0 sampled at a CLK rising edge resets the block.
REQ-005 Port D_IN  input  1  raw asynchronous switch/data input; may glitch or bounce at any time.
REQ-006 Port Q  output  1  debounced, registered level of D_IN; this is the clean D fed to the downstream flip-flop stage.
REQ-007 Port RISE  output  1  registered one-cycle pulse on each accepted 0->1 transition of Q.
REQ-008 Port FALL  output  1  registered one-cycle pulse on each accepted 1->0 transition of Q.
REQ-009 Port PRESS_CNT  output  8  count of accepted 0->1 transitions since reset.

Function
REQ-010 D_IN shall pass through a SYNC_STAGES-deep flip-flop chain; the last stage is sync_out, and no other logic shall sample D_IN.
REQ-011 The FSM shall have exactly four states: S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW; Q is 1 exactly in S_HIGH and S_WAIT_LOW.
REQ-012 In S_LOW with sync_out==1: go to S_WAIT_HIGH and load count=1; otherwise remain and hold count=0.
REQ-013 In S_WAIT_HIGH with sync_out==0: return to S_LOW and clear count; Q stays 0 and no pulse is issued.
REQ-014 In S_WAIT_HIGH with sync_out==1 and count==STABLE_CYCLES-1: go to S_HIGH, clear count, set Q=1 and RISE=1 at the same edge; otherwise increment count.
REQ-015 S_HIGH and S_WAIT_LOW shall mirror REQ-012..014 with polarities inverted, issuing FALL=1 and Q=0 on acceptance.
REQ-016 Latency: numbering edge 1 as the first edge that captures a new stable D_IN level, Q and the pulse change at edge SYNC_STAGES+STABLE_CYCLES (defaults: edge 6).
REQ-017 RISE and FALL shall each be high for exactly one cycle per accepted transition, shall never be high in the same cycle, and shall be 0 in every other cycle.
REQ-018 The count register shall be 8 bits and shall never exceed STABLE_CYCLES-1.
REQ-019 PRESS_CNT shall increment by 1 at the same edge RISE is set, and shall wrap 255->0 without any flag.
REQ-020 Any glitch on sync_out shorter than STABLE_CYCLES cycles shall leave Q, RISE, FALL and PRESS_CNT unchanged.
REQ-021 Parameter values outside their legal ranges are unsupported; no runtime checking is required.

Reset
REQ-022 When RST==0 at a rising edge, the following shall clear to 0: all synchronizer stages, count, Q, RISE, FALL and PRESS_CNT; the state shall go to S_LOW.
REQ-023 Reset shall override all other activity, including a reset that arrives mid-S_WAIT_HIGH or in the same cycle as an acceptance, in which case no pulse and no PRESS_CNT increment occur.
REQ-024 If D_IN==1 at reset release, the block shall treat it as a fresh 0->1 transition, so RISE fires SYNC_STAGES+STABLE_CYCLES edges after release.
REQ-025 Reset shall not be used asynchronously; all outputs change only on CLK rising edges.

Verification
REQ-026 Defaults; RST=0 for 2 edges, then 1, D_IN=0 -> Q=0, RISE=0, FALL=0, PRESS_CNT=0 at every edge.
REQ-027 D_IN 0->1 held stable -> Q=1 and RISE=1 at edge 6, RISE=0 at edge 7, PRESS_CNT=1.
REQ-028 D_IN bounces 1,0,1,0 with 2-cycle periods, then is held at 1 -> a single RISE only, 6 edges after the last bounce is captured; no FALL.
REQ-029 Q=1, then D_IN=0 for 3 cycles, then back to 1 -> Q stays 1 with no FALL; D_IN=0 held -> FALL at edge 6, Q=0.
REQ-030 256 clean presses -> PRESS_CNT reads 255 then 0, RISE count is 256.
REQ-031 RST=0 asserted 2 cycles into S_WAIT_HIGH while D_IN stays 1 -> no RISE during reset; after release, RISE at edge 6 and PRESS_CNT=1.
